// File: rtl/vec_alu_pipe.sv
// vec_alu_pipe: two-stage pipelined SIMD ALU with lane-wise arithmetic/logic, cross-lane sum and valid/ready flow control.
// Stage 1 registers operands plus split multiply partial products and the lane-sum tree; stage 2 finalises Result/Zero.
module vec_alu_pipe #(
    parameter int REG_WIDTH  = 256,
    parameter int ELEM_WIDTH = 32,
    localparam int NUM_ELEM  = REG_WIDTH / ELEM_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_WIDTH-1:0]  A,
    input  logic [REG_WIDTH-1:0]  B,
    input  logic [ELEM_WIDTH-1:0] Imm,
    input  logic                  UseImm,
    input  logic [2:0]            ALUControl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_WIDTH-1:0]  Result,
    output logic                  Zero
);
    localparam int LW = ELEM_WIDTH / 2;
    localparam int HW = ELEM_WIDTH - LW;
    typedef logic [ELEM_WIDTH-1:0] elem_t;
    typedef logic [HW-1:0] half_t;

    elem_t [NUM_ELEM-1:0] av, bv, a1, b1, pll, pll1, res_n, t;
    half_t [NUM_ELEM-1:0] px, px1;
    elem_t red, red1;
    logic [2:0] op1;
    logic v1, advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign av = A;
    assign bv = UseImm ? {NUM_ELEM{Imm}} : B;

    // low product = lo*lo + ((lo*hi + hi*lo) << LW); only the low HW bits of the cross terms survive
    genvar i;
    generate
        for (i = 0; i < NUM_ELEM; i++) begin : g_lane
            elem_t mul;
            assign pll[i] = elem_t'(av[i][LW-1:0]) * elem_t'(bv[i][LW-1:0]);
            assign px[i]  = half_t'(av[i][LW-1:0]) * half_t'(bv[i][ELEM_WIDTH-1:LW])
                          + half_t'(av[i][ELEM_WIDTH-1:LW]) * half_t'(bv[i][LW-1:0]);
            assign mul = pll1[i] + (elem_t'(px1[i]) << LW);
            assign res_n[i] = op1 == 3'd0 ? a1[i] + b1[i] :
                              op1 == 3'd1 ? a1[i] - b1[i] :
                              op1 == 3'd2 ? b1[i] :
                              op1 == 3'd3 ? mul :
                              op1 == 3'd4 ? a1[i] & b1[i] :
                              op1 == 3'd5 ? a1[i] | b1[i] :
                              op1 == 3'd6 ? a1[i] ^ b1[i] :
                              (i == 0 ? red1 : '0);
        end
    endgenerate

    always_comb begin
        t = av;
        for (int s = 1; s < NUM_ELEM; s = s * 2)
            for (int j = 0; j + s < NUM_ELEM; j = j + 2 * s)
                t[j] = t[j] + t[j + s];
        red = t[0];
    end

    always_ff @(posedge clk) begin
        if (advance && in_valid) begin
            a1   <= av;
            b1   <= bv;
            op1  <= ALUControl;
            pll1 <= pll;
            px1  <= px;
            red1 <= red;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            out_valid <= 1'b0;
            Result    <= '0;
            Zero      <= 1'b0;
        end else if (flush) begin
            v1        <= 1'b0;
            out_valid <= 1'b0;
        end else if (advance) begin
            v1        <= in_valid;
            out_valid <= v1;
            if (v1) begin
                Result <= res_n;
                Zero   <= ~|res_n;
            end
        end
    end
endmodule
